// File: rtl/axi4_decerr_slave_if.sv
// axi4_decerr_slave_if: AXI4 bus bundle between a master and the DECERR default slave
interface axi4_decerr_slave_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]   awid;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   arid;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awid, awvalid, wdata, wlast, wvalid, bready, arid, arlen, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output awid, awvalid, wdata, wlast, wvalid, bready, arid, arlen, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi4_decerr_slave.sv
// axi4_decerr_slave: default slave completing every write/read with DECERR and counting them
module axi4_decerr_slave #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    axi4_decerr_slave_if.slave   bus,
    output logic [CNT_WIDTH-1:0] decerr_wr_cnt,
    output logic [CNT_WIDTH-1:0] decerr_rd_cnt
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e             w_q, w_d;
    r_state_e             r_q, r_d;
    logic [ID_WIDTH-1:0]  bid_q, bid_d, rid_q, rid_d;
    logic [7:0]           beat_q, beat_d;
    logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic                 unused_wdata;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_q      <= W_IDLE;
            r_q      <= R_IDLE;
            bid_q    <= '0;
            rid_q    <= '0;
            beat_q   <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            w_q      <= w_d;
            r_q      <= r_d;
            bid_q    <= bid_d;
            rid_q    <= rid_d;
            beat_q   <= beat_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Write channel: beats are swallowed; only the completion is visible
    always_comb begin
        w_d      = w_q;
        bid_d    = bid_q;
        wr_cnt_d = wr_cnt_q;
        unique case (w_q)
            W_IDLE: if (bus.awvalid) begin
                w_d   = W_DATA;
                bid_d = bus.awid;
            end
            W_DATA: if (bus.wvalid && bus.wlast) w_d = W_RESP;
            W_RESP: if (bus.bready) begin
                w_d      = W_IDLE;
                wr_cnt_d = &wr_cnt_q ? wr_cnt_q : wr_cnt_q + CNT_WIDTH'(1);
            end
            default: w_d = W_IDLE;
        endcase
    end

    // Read channel: beat_q counts remaining beats, so zero marks the last one
    always_comb begin
        r_d      = r_q;
        rid_d    = rid_q;
        beat_d   = beat_q;
        rd_cnt_d = rd_cnt_q;
        if (r_q == R_IDLE) begin
            if (bus.arvalid) begin
                r_d    = R_DATA;
                rid_d  = bus.arid;
                beat_d = bus.arlen;
            end
        end else if (bus.rready) begin
            if (beat_q == 8'd0) begin
                r_d      = R_IDLE;
                rd_cnt_d = &rd_cnt_q ? rd_cnt_q : rd_cnt_q + CNT_WIDTH'(1);
            end else begin
                beat_d = beat_q - 8'd1;
            end
        end
    end

    assign bus.awready   = w_q == W_IDLE;
    assign bus.wready    = w_q == W_DATA;
    assign bus.bvalid    = w_q == W_RESP;
    assign bus.bid       = bid_q;
    assign bus.bresp     = 2'b11;
    assign bus.arready   = r_q == R_IDLE;
    assign bus.rvalid    = r_q == R_DATA;
    assign bus.rlast     = (r_q == R_DATA) && (beat_q == 8'd0);
    assign bus.rid       = rid_q;
    assign bus.rresp     = 2'b11;
    assign bus.rdata     = {DATA_WIDTH{1'b0}};
    assign decerr_wr_cnt = wr_cnt_q;
    assign decerr_rd_cnt = rd_cnt_q;
    assign unused_wdata  = ^bus.wdata;
endmodule

// File: tb/tb_axi4_decerr_slave.sv
// tb_axi4_decerr_slave: directed checks of the DECERR default slave, incl. a narrow-counter instance
module tb_axi4_decerr_slave;
    logic aclk = 1'b0;
    logic areset;
    logic [15:0] wr_cnt, rd_cnt;
    logic [3:0]  wr_cnt2, rd_cnt2;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 aclk = ~aclk;

    axi4_decerr_slave_if #(.ID_WIDTH(4), .DATA_WIDTH(64)) bus ();
    axi4_decerr_slave_if #(.ID_WIDTH(4), .DATA_WIDTH(64)) bus2 ();

    axi4_decerr_slave #(.ID_WIDTH(4), .DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
        .aclk(aclk), .areset(areset), .bus(bus.slave),
        .decerr_wr_cnt(wr_cnt), .decerr_rd_cnt(rd_cnt)
    );

    axi4_decerr_slave #(.ID_WIDTH(4), .DATA_WIDTH(64), .CNT_WIDTH(4)) dut_sat (
        .aclk(aclk), .areset(areset), .bus(bus2.slave),
        .decerr_wr_cnt(wr_cnt2), .decerr_rd_cnt(rd_cnt2)
    );

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.awid = '0; bus.awvalid = 0; bus.wdata = '0; bus.wlast = 0; bus.wvalid = 0; bus.bready = 0;
        bus.arid = '0; bus.arlen = '0; bus.arvalid = 0; bus.rready = 0;
        bus2.awid = '0; bus2.awvalid = 0; bus2.wdata = '0; bus2.wlast = 0; bus2.wvalid = 0; bus2.bready = 0;
        bus2.arid = '0; bus2.arlen = '0; bus2.arvalid = 0; bus2.rready = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        areset = 1;
        tick(); tick();
        n_tests++;
        if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast, bus.bid, bus.rid} !== {6'b110000, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs got %h exp %h", {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast, bus.bid, bus.rid}, {6'b110000, 8'd0});
        end
        n_tests++;
        if ({wr_cnt, rd_cnt} !== 32'd0) begin n_fail++; $display("FAIL reset_counters got %h exp 0", {wr_cnt, rd_cnt}); end
        areset = 0;
        tick();
    endtask

    task automatic test_single_write;
        bus.awvalid = 1; bus.awid = 4'd3;
        tick();
        bus.awvalid = 0; bus.awid = 4'd0;
        n_tests++;
        if ({bus.awready, bus.wready, bus.bvalid} !== 3'b010) begin n_fail++; $display("FAIL w1_data_phase got %b exp 010", {bus.awready, bus.wready, bus.bvalid}); end
        bus.wvalid = 1; bus.wlast = 1; bus.wdata = 64'hDEAD_BEEF_0123_4567; bus.bready = 1;
        tick();
        bus.wvalid = 0; bus.wlast = 0;
        n_tests++;
        if ({bus.bvalid, bus.bid, bus.bresp, bus.awready, bus.wready} !== {1'b1, 4'd3, 2'b11, 2'b00}) begin
            n_fail++; $display("FAIL w1_resp got %h exp %h", {bus.bvalid, bus.bid, bus.bresp, bus.awready, bus.wready}, {1'b1, 4'd3, 2'b11, 2'b00});
        end
        tick();
        bus.bready = 0;
        n_tests++;
        if ({bus.bvalid, bus.awready, wr_cnt} !== {2'b01, 16'd1}) begin n_fail++; $display("FAIL w1_done got %h exp %h", {bus.bvalid, bus.awready, wr_cnt}, {2'b01, 16'd1}); end
    endtask

    task automatic test_single_read;
        int beats = 0;
        int cyc = 0;
        bus.arvalid = 1; bus.arid = 4'd5; bus.arlen = 8'd3; bus.rready = 1;
        tick();
        bus.arvalid = 0; bus.arid = 4'd0; bus.arlen = 8'd0;
        while (bus.rvalid && cyc < 20) begin
            n_tests++;
            if ({bus.rid, bus.rresp, bus.rdata, bus.rlast, bus.arready} !== {4'd5, 2'b11, 64'd0, beats == 3, 1'b0}) begin
                n_fail++; $display("FAIL r1_beat%0d got rid=%0d rresp=%b rdata=%h rlast=%b arready=%b", beats, bus.rid, bus.rresp, bus.rdata, bus.rlast, bus.arready);
            end
            beats++;
            cyc++;
            tick();
        end
        bus.rready = 0;
        n_tests++;
        if (beats != 4) begin n_fail++; $display("FAIL r1_beat_count got %0d exp 4", beats); end
        n_tests++;
        if ({bus.arready, rd_cnt} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL r1_done got %h exp %h", {bus.arready, rd_cnt}, {1'b1, 16'd1}); end
    endtask

    task automatic test_w_before_aw;
        bus.wvalid = 1; bus.wlast = 1;
        tick(); tick();
        n_tests++;
        if ({bus.wready, bus.awready, bus.bvalid} !== 3'b010) begin n_fail++; $display("FAIL wstall_idle got %b exp 010", {bus.wready, bus.awready, bus.bvalid}); end
        bus.awvalid = 1; bus.awid = 4'd12;
        tick();
        bus.awvalid = 0;
        n_tests++;
        if ({bus.wready, bus.bvalid} !== 2'b10) begin n_fail++; $display("FAIL wstall_data got %b exp 10", {bus.wready, bus.bvalid}); end
        tick();
        bus.wvalid = 0; bus.wlast = 0;
        tick();
        n_tests++;
        if ({bus.bvalid, bus.bid, wr_cnt} !== {1'b1, 4'd12, 16'd1}) begin
            n_fail++; $display("FAIL wstall_bhold got %h exp %h", {bus.bvalid, bus.bid, wr_cnt}, {1'b1, 4'd12, 16'd1});
        end
        bus.bready = 1;
        tick();
        bus.bready = 0;
        n_tests++;
        if ({bus.bvalid, wr_cnt} !== {1'b0, 16'd2}) begin n_fail++; $display("FAIL wstall_done got %h exp %h", {bus.bvalid, wr_cnt}, {1'b0, 16'd2}); end
    endtask

    task automatic test_long_read;
        int beats = 0;
        int cyc = 0;
        bus.arvalid = 1; bus.arid = 4'd7; bus.arlen = 8'd255;
        tick();
        bus.arvalid = 0; bus.arlen = 8'd0;
        while (beats < 256 && cyc < 3000) begin
            n_tests++;
            if ({bus.rvalid, bus.arready, bus.rlast, bus.rid, bus.rresp, bus.rdata} !== {2'b10, beats == 255, 4'd7, 2'b11, 64'd0}) begin
                n_fail++; $display("FAIL rlong_beat%0d got rvalid=%b arready=%b rlast=%b rid=%0d rresp=%b", beats, bus.rvalid, bus.arready, bus.rlast, bus.rid, bus.rresp);
            end
            bus.rready = 1'($urandom_range(0, 1));
            if (bus.rready) beats++;
            cyc++;
            tick();
        end
        bus.rready = 0;
        n_tests++;
        if (beats != 256) begin n_fail++; $display("FAIL rlong_count got %0d exp 256 (cycle budget)", beats); end
        n_tests++;
        if ({bus.rvalid, bus.arready, rd_cnt} !== {2'b01, 16'd2}) begin n_fail++; $display("FAIL rlong_done got %h exp %h", {bus.rvalid, bus.arready, rd_cnt}, {2'b01, 16'd2}); end
    endtask

    task automatic test_back_to_back;
        areset = 1; #2; areset = 0;
        bus.awvalid = 1; bus.awid = 4'd9; bus.arvalid = 1; bus.arid = 4'd2; bus.arlen = 8'd1;
        tick();
        bus.awvalid = 0; bus.arvalid = 0; bus.arlen = 8'd0;
        n_tests++;
        if ({bus.awready, bus.arready, bus.wready, bus.rvalid, bus.rlast, bus.rid} !== {5'b00110, 4'd2}) begin
            n_fail++; $display("FAIL bb_accept got %h exp %h", {bus.awready, bus.arready, bus.wready, bus.rvalid, bus.rlast, bus.rid}, {5'b00110, 4'd2});
        end
        bus.wvalid = 1; bus.wlast = 0; bus.rready = 1; bus.bready = 1;
        tick();
        n_tests++;
        if ({bus.rvalid, bus.rlast, bus.wready} !== 3'b111) begin n_fail++; $display("FAIL bb_rlast got %b exp 111", {bus.rvalid, bus.rlast, bus.wready}); end
        tick();
        n_tests++;
        if ({bus.rvalid, bus.arready, bus.wready, rd_cnt} !== {3'b011, 16'd1}) begin
            n_fail++; $display("FAIL bb_rdone got %h exp %h", {bus.rvalid, bus.arready, bus.wready, rd_cnt}, {3'b011, 16'd1});
        end
        tick();
        bus.wlast = 1;
        tick();
        bus.wvalid = 0; bus.wlast = 0;
        n_tests++;
        if ({bus.bvalid, bus.bid, bus.bresp, wr_cnt} !== {1'b1, 4'd9, 2'b11, 16'd0}) begin
            n_fail++; $display("FAIL bb_bresp got %h exp %h", {bus.bvalid, bus.bid, bus.bresp, wr_cnt}, {1'b1, 4'd9, 2'b11, 16'd0});
        end
        tick();
        bus.bready = 0; bus.rready = 0;
        n_tests++;
        if ({bus.bvalid, bus.awready, wr_cnt, rd_cnt} !== {2'b01, 16'd1, 16'd1}) begin
            n_fail++; $display("FAIL bb_done got %h exp %h", {bus.bvalid, bus.awready, wr_cnt, rd_cnt}, {2'b01, 16'd1, 16'd1});
        end
    endtask

    task automatic test_reset_mid_read;
        bus.arvalid = 1; bus.arid = 4'd4; bus.arlen = 8'd3; bus.rready = 1;
        tick();
        bus.arvalid = 0; bus.arlen = 8'd0;
        tick();
        bus.rready = 0;
        n_tests++;
        if ({bus.rvalid, bus.rlast, bus.arready} !== 3'b100) begin n_fail++; $display("FAIL rst_mid_beat2 got %b exp 100", {bus.rvalid, bus.rlast, bus.arready}); end
        #1 areset = 1;
        #1;
        n_tests++;
        if ({bus.rvalid, bus.arready, wr_cnt, rd_cnt} !== {2'b01, 32'd0}) begin
            n_fail++; $display("FAIL rst_mid_async got %h exp %h", {bus.rvalid, bus.arready, wr_cnt, rd_cnt}, {2'b01, 32'd0});
        end
        #1 areset = 0;
        tick();
        bus.arvalid = 1; bus.arid = 4'd6; bus.arlen = 8'd0; bus.rready = 1;
        tick();
        bus.arvalid = 0;
        n_tests++;
        if ({bus.rvalid, bus.rlast, bus.rid} !== {2'b11, 4'd6}) begin n_fail++; $display("FAIL rst_mid_newbeat got %h exp %h", {bus.rvalid, bus.rlast, bus.rid}, {2'b11, 4'd6}); end
        tick();
        bus.rready = 0;
        n_tests++;
        if ({bus.rvalid, rd_cnt} !== {1'b0, 16'd1}) begin n_fail++; $display("FAIL rst_mid_newdone got %h exp %h", {bus.rvalid, rd_cnt}, {1'b0, 16'd1}); end
    endtask

    // Narrow 4-bit counters: a write completes every 3 cycles, a read every 2
    task automatic test_saturation;
        int exp_w, exp_r;
        bus2.awvalid = 1; bus2.awid = 4'd1; bus2.wvalid = 1; bus2.wlast = 1; bus2.bready = 1;
        bus2.arvalid = 1; bus2.arid = 4'd1; bus2.arlen = 8'd0; bus2.rready = 1;
        for (int i = 1; i <= 51; i++) begin
            tick();
            exp_w = (i / 3 > 15) ? 15 : i / 3;
            exp_r = (i / 2 > 15) ? 15 : i / 2;
            n_tests++;
            if ({wr_cnt2, rd_cnt2} !== {4'(exp_w), 4'(exp_r)}) begin
                n_fail++; $display("FAIL sat_cycle%0d got wr=%0d rd=%0d exp wr=%0d rd=%0d", i, wr_cnt2, rd_cnt2, exp_w, exp_r);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_w_before_aw();
        test_long_read();
        test_back_to_back();
        test_reset_mid_read();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
